// File: rtl/mic_array_pkg.sv
// Shared definitions for the INMP441 microphone-array capture path:
// sequencer state encoding and default sizing of the array and its timers.
package mic_array_pkg;

  // Array size and timing defaults
  localparam int NUM_MICS_DEFAULT      = 4;
  localparam int SETTLE_FRAMES_DEFAULT = 4096;  // 2^18 BCLK wake-up / 64 BCLK per WS frame
  localparam int WS_TIMEOUT_DEFAULT    = 8192;  // clk cycles without a WS falling edge
  localparam int FRAME_W_DEFAULT       = 16;

  // Run-control sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_ARM    = 3'd2,
    ST_RUN    = 3'd3,
    ST_STOP   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mic_frame_collector.sv
// Collects per-mic left-channel word-done pulses into a frame mask.
// Signals a completed frame once every mic has delivered, and a skew event
// when a WS frame boundary arrives with only part of the array captured.
// A pulse that coincides with the WS falling edge still counts toward the
// frame that is ending.
module mic_frame_collector
  import mic_array_pkg::*;
#(
  parameter int NUM_MICS = NUM_MICS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  input  logic                ws_fall,
  input  logic [NUM_MICS-1:0] rx_valid,
  output logic                complete,
  output logic                skew
);

  logic [NUM_MICS-1:0] mask;
  logic [NUM_MICS-1:0] merged;
  logic                active;
  logic                full;
  logic                any;
  logic                clear;

  // Flush (stop request) discards whatever the current cycle delivered
  assign active   = enable & ~flush;
  assign merged   = mask | rx_valid;
  assign full     = &merged;
  assign any      = |merged;
  assign complete = active & full;
  assign skew     = active & ws_fall & any & ~full;

  // Mask restarts after a completed frame, at every frame boundary, and
  // whenever collection is not running
  assign clear = ~active | full | ws_fall;

  for (genvar gi = 0; gi < NUM_MICS; gi++) begin : g_mic
    // Per-mic capture flag for the frame currently being collected
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mask[gi] <= 1'b0;
      end else if (clear) begin
        mask[gi] <= 1'b0;
      end else begin
        mask[gi] <= merged[gi];
      end
    end
  end

endmodule

// File: rtl/mic_capture_sequencer.sv
// Run-control sequencer for the shared-clock INMP441 array. Starts the
// BCLK/WS generator, waits out the mic settle window, enables the receivers
// on a left-channel frame boundary, and presents completed array frames to
// the beamformer over a valid/ready handshake. Skew, overrun and clock-loss
// conditions raise sticky error flags.
module mic_capture_sequencer
  import mic_array_pkg::*;
#(
  parameter int NUM_MICS      = NUM_MICS_DEFAULT,
  parameter int SETTLE_FRAMES = SETTLE_FRAMES_DEFAULT,
  parameter int WS_TIMEOUT    = WS_TIMEOUT_DEFAULT,
  parameter int FRAME_W       = FRAME_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clr_err,
  input  logic                ws,
  input  logic [NUM_MICS-1:0] rx_valid,
  input  logic                bf_ready,
  output logic                i2s_clk_en,
  output logic                rx_en,
  output logic                frame_valid,
  output logic [FRAME_W-1:0]  frame_idx,
  output logic                busy,
  output logic                err_skew,
  output logic                err_overrun,
  output logic                err_clk
);

  localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);
  localparam int WD_W     = $clog2(WS_TIMEOUT + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);
  localparam logic [WD_W-1:0]     WD_LAST     = WD_W'(WS_TIMEOUT - 1);

  seq_state_t           state;
  logic                 ws_q;
  logic                 ws_fall;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic [FRAME_W-1:0]   seq_cnt;
  logic                 active;
  logic                 timeout;
  logic                 accept;
  logic                 complete;
  logic                 skew;

  // Falling WS edge marks the start of a left-channel frame
  assign ws_fall = ws_q & ~ws;
  assign active  = (state != ST_IDLE);
  // Watchdog expires on the cycle its count would reach WS_TIMEOUT
  assign timeout = active & ~ws_fall & (wd_cnt == WD_LAST);
  assign accept  = frame_valid & bf_ready;

  mic_frame_collector #(
    .NUM_MICS (NUM_MICS)
  ) u_collector (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state == ST_RUN),
    .flush    (stop),
    .ws_fall  (ws_fall),
    .rx_valid (rx_valid),
    .complete (complete),
    .skew     (skew)
  );

  // Delayed WS for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q <= 1'b0;
    end else begin
      ws_q <= ws;
    end
  end

  // Sequencer FSM with frame handshake, watchdog and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      i2s_clk_en  <= 1'b0;
      rx_en       <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_idx   <= '0;
      seq_cnt     <= '0;
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      err_skew    <= 1'b0;
      err_overrun <= 1'b0;
      err_clk     <= 1'b0;
    end else begin
      // Clear first so an error event in the same cycle wins
      if (clr_err) begin
        err_skew    <= 1'b0;
        err_overrun <= 1'b0;
        err_clk     <= 1'b0;
      end
      if (skew) begin
        err_skew <= 1'b1;
      end

      // One-deep output holding register; a completion may replace a frame
      // that is being accepted this same cycle
      if (complete) begin
        seq_cnt <= seq_cnt + 1'b1;
        if (!frame_valid || bf_ready) begin
          frame_valid <= 1'b1;
          frame_idx   <= seq_cnt;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (accept) begin
        frame_valid <= 1'b0;
      end

      // Watchdog counts clk cycles since the last WS falling edge
      if (!active || ws_fall) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state      <= ST_WARMUP;
            i2s_clk_en <= 1'b1;
            busy       <= 1'b1;
            settle_cnt <= '0;
          end
        end
        ST_WARMUP: begin
          if (stop) begin
            state <= ST_STOP;
          end else if (ws_fall) begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= ST_ARM;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (stop) begin
            state <= ST_STOP;
          end else if (ws_fall) begin
            state <= ST_RUN;
            rx_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_STOP;
            rx_en <= 1'b0;
          end
        end
        ST_STOP: begin
          // Clock halts only on a frame boundary
          if (ws_fall) begin
            state      <= ST_IDLE;
            i2s_clk_en <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          i2s_clk_en <= 1'b0;
          rx_en      <= 1'b0;
          busy       <= 1'b0;
        end
      endcase

      // Clock loss aborts the run from any active state
      if (timeout) begin
        state       <= ST_IDLE;
        i2s_clk_en  <= 1'b0;
        rx_en       <= 1'b0;
        busy        <= 1'b0;
        frame_valid <= 1'b0;
        err_clk     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mic_capture_sequencer.sv
// Bench for mic_capture_sequencer: directed scenarios plus a randomized run
// checked against a frame-level behavioural model of the capture rules.
`timescale 1ns/1ps
module tb_mic_capture_sequencer;

  localparam int SETTLE = 4;
  localparam int WS_TO  = 200;
  localparam int WS_PER = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clr_err = 1'b0;
  logic        ws = 1'b0;
  logic [3:0]  rx_valid = 4'h0;
  logic        bf_ready = 1'b0;
  logic        i2s_clk_en, rx_en, frame_valid, busy;
  logic        err_skew, err_overrun, err_clk;
  logic [15:0] frame_idx;

  int n_checks = 0;
  int n_fail = 0;

  // WS generator state (gated by i2s_clk_en like the real generator)
  int gen_cnt = 0;
  bit freeze = 0;
  bit fall_now = 0;       // WS falls at the next rising clk edge

  // Observations
  int          fv_cycles = 0;
  logic [15:0] acc_q[$];

  // Behavioural model state
  logic [3:0]  m_mask;
  bit          m_valid, m_overrun, m_skew;
  logic [15:0] m_idx, m_seq;

  mic_capture_sequencer #(
    .NUM_MICS      (4),
    .SETTLE_FRAMES (SETTLE),
    .WS_TIMEOUT    (WS_TO),
    .FRAME_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clr_err     (clr_err),
    .ws          (ws),
    .rx_valid    (rx_valid),
    .bf_ready    (bf_ready),
    .i2s_clk_en  (i2s_clk_en),
    .rx_en       (rx_en),
    .frame_valid (frame_valid),
    .frame_idx   (frame_idx),
    .busy        (busy),
    .err_skew    (err_skew),
    .err_overrun (err_overrun),
    .err_clk     (err_clk)
  );

  always #5 clk = ~clk;

  // Advance one clock: log handshake, wait to the falling edge, update WS
  task automatic step();
    logic old_ws;
    if (frame_valid === 1'b1 && bf_ready === 1'b1) begin
      acc_q.push_back(frame_idx);
      $display("frame accepted: idx=%0d at %0t", frame_idx, $time);
    end
    @(negedge clk);
    if (frame_valid === 1'b1) fv_cycles++;
    old_ws = ws;
    if (i2s_clk_en !== 1'b1) begin
      gen_cnt = 0;
      ws = 1'b0;
    end else if (!freeze) begin
      gen_cnt = (gen_cnt + 1) % WS_PER;
      ws = (gen_cnt >= WS_PER / 2);
    end
    fall_now = old_ws & ~ws;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr_err = 1'b0;
    rx_valid = 4'h0; bf_ready = 1'b0; freeze = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    acc_q.delete();
    fv_cycles = 0;
  endtask

  // Reset, start, and run until the receivers are enabled
  task automatic bring_up();
    int guard;
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (rx_en !== 1'b1 && guard < 1200) begin
      step();
      guard++;
    end
    n_checks++;
    if (rx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL bring_up_rx_en: rx_en=%b after %0d cycles, required 1", rx_en, guard);
    end
  endtask

  // Drive one WS frame: pulse selected mics at staggered offsets, end after the boundary
  task automatic run_frame(input logic [3:0] mics, input logic rdy, input logic clr_at_fall);
    bit was_fall;
    int off;
    was_fall = 0;
    off = 0;
    while (!was_fall && off < 400) begin
      rx_valid = 4'h0;
      for (int i = 0; i < 4; i++) if (mics[i] && off == 10 + 12 * i) rx_valid[i] = 1'b1;
      bf_ready = rdy;
      was_fall = fall_now;
      clr_err = clr_at_fall & was_fall;
      step();
      off++;
    end
    rx_valid = 4'h0;
    clr_err = 1'b0;
    n_checks++;
    if (!was_fall) begin
      n_fail++;
      $display("FAIL frame_boundary: no WS fall within %0d cycles, required one", off);
    end
  endtask

  task automatic test_reset();
    $display("test_reset");
    do_reset();
    n_checks++;
    if ({i2s_clk_en, rx_en, frame_valid, busy, err_skew, err_overrun, err_clk} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {i2s_clk_en, rx_en, frame_valid, busy, err_skew, err_overrun, err_clk});
    end
    n_checks++;
    if (frame_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_idx: got %0d, required 0", frame_idx);
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || i2s_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_same_cycle: busy=%b clk_en=%b, required 0 0", busy, i2s_clk_en);
    end
  endtask

  task automatic test_startup();
    int falls, rise_at, exp_at, clk_drop;
    bit f;
    $display("test_startup");
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (i2s_clk_en !== 1'b1 || busy !== 1'b1 || rx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL start_enables: clk_en=%b busy=%b rx_en=%b, required 1 1 0", i2s_clk_en, busy, rx_en);
    end
    falls = 0; rise_at = -1; exp_at = -1; clk_drop = 0;
    for (int s = 1; s <= 1000 && rise_at < 0; s++) begin
      f = fall_now;
      step();
      if (f) begin
        falls++;
        if (falls == SETTLE + 1) exp_at = s;
      end
      if (rx_en === 1'b1) rise_at = s;
      if (i2s_clk_en !== 1'b1) clk_drop++;
    end
    n_checks++;
    if (rise_at != exp_at || exp_at < 0) begin
      n_fail++;
      $display("FAIL rx_en_rise: rose at cycle %0d, required %0d (after fall %0d)", rise_at, exp_at, SETTLE + 1);
    end
    n_checks++;
    if (clk_drop != 0) begin
      n_fail++;
      $display("FAIL warmup_clk_en: dropped %0d cycles, required 0", clk_drop);
    end
    n_checks++;
    if (fv_cycles != 0) begin
      n_fail++;
      $display("FAIL warmup_frame_valid: %0d cycles high, required 0", fv_cycles);
    end
  endtask

  task automatic test_frames();
    $display("test_frames");
    bring_up();
    for (int k = 0; k < 3; k++) run_frame(4'hF, 1'b1, 1'b0);
    n_checks++;
    if (acc_q.size() != 3 || fv_cycles != 3) begin
      n_fail++;
      $display("FAIL frames_count: accepted %0d, valid cycles %0d, required 3 3", acc_q.size(), fv_cycles);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (acc_q[k] !== 16'(k)) begin
          n_fail++;
          $display("FAIL frames_idx%0d: got %0d, required %0d", k, acc_q[k], k);
        end
      end
    end
    n_checks++;
    if (err_skew !== 1'b0 || err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL frames_errors: skew=%b overrun=%b, required 0 0", err_skew, err_overrun);
    end
  endtask

  task automatic test_overrun();
    $display("test_overrun");
    bring_up();
    run_frame(4'hF, 1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_idx !== 16'd0 || err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_first: valid=%b idx=%0d ovr=%b, required 1 0 0", frame_valid, frame_idx, err_overrun);
    end
    run_frame(4'hF, 1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_idx !== 16'd0 || err_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_held: valid=%b idx=%0d ovr=%b, required 1 0 1", frame_valid, frame_idx, err_overrun);
    end
    run_frame(4'hF, 1'b1, 1'b0);
    n_checks++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL overrun_accepts: got %0d frames, required 2", acc_q.size());
    end else begin
      n_checks++;
      if (acc_q[0] !== 16'd0 || acc_q[1] !== 16'd2) begin
        n_fail++;
        $display("FAIL overrun_idx: got %0d,%0d, required 0,2", acc_q[0], acc_q[1]);
      end
    end
  endtask

  task automatic test_skew();
    $display("test_skew");
    bring_up();
    run_frame(4'b0111, 1'b1, 1'b0);
    n_checks++;
    if (err_skew !== 1'b1 || fv_cycles != 0) begin
      n_fail++;
      $display("FAIL skew_detect: skew=%b valid cycles=%0d, required 1 0", err_skew, fv_cycles);
    end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++;
    if (err_skew !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_clear: got %b, required 0", err_skew);
    end
    run_frame(4'b0111, 1'b1, 1'b1);
    n_checks++;
    if (err_skew !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_event_wins: got %b, required 1", err_skew);
    end
    run_frame(4'hF, 1'b1, 1'b0);
    n_checks++;
    if (acc_q.size() != 1 || (acc_q.size() == 1 && acc_q[0] !== 16'd0)) begin
      n_fail++;
      $display("FAIL skew_recover: accepted %0d frames, required one with idx 0", acc_q.size());
    end
  endtask

  task automatic test_stop();
    int drops, guard;
    bit was_fall;
    $display("test_stop");
    bring_up();
    for (int c = 0; c < 30; c++) begin
      rx_valid = (c == 5) ? 4'b0011 : 4'h0;
      step();
    end
    rx_valid = 4'h0;
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++;
    if (rx_en !== 1'b0 || i2s_clk_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_immediate: rx_en=%b clk_en=%b busy=%b, required 0 1 1", rx_en, i2s_clk_en, busy);
    end
    drops = 0; guard = 0; was_fall = 0;
    while (!was_fall && guard < 300) begin
      was_fall = fall_now;
      step();
      guard++;
      if (!was_fall && i2s_clk_en !== 1'b1) drops++;
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL stop_clk_hold: clk_en low %0d cycles before boundary, required 0", drops);
    end
    n_checks++;
    if (i2s_clk_en !== 1'b0 || busy !== 1'b0 || err_skew !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_halt: clk_en=%b busy=%b skew=%b, required 0 0 0", i2s_clk_en, busy, err_skew);
    end
    for (int c = 0; c < 250; c++) step();
    n_checks++;
    if (err_clk !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_watchdog: err_clk=%b busy=%b, required 0 0", err_clk, busy);
    end
  endtask

  task automatic test_timeout();
    int first_n;
    $display("test_timeout");
    bring_up();
    freeze = 1;
    first_n = -1;
    for (int n = 1; n <= 260 && first_n < 0; n++) begin
      step();
      if (err_clk === 1'b1) first_n = n;
    end
    n_checks++;
    if (first_n != WS_TO) begin
      n_fail++;
      $display("FAIL timeout_cycle: err_clk rose after %0d cycles, required %0d", first_n, WS_TO);
    end
    n_checks++;
    if (i2s_clk_en !== 1'b0 || rx_en !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_outputs: clk_en=%b rx_en=%b busy=%b valid=%b, required 0 0 0 0",
               i2s_clk_en, rx_en, busy, frame_valid);
    end
    freeze = 0;
  endtask

  task automatic test_async_reset();
    $display("test_async_reset");
    bring_up();
    run_frame(4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({i2s_clk_en, rx_en, frame_valid, busy} !== 4'b0 || frame_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: en/rx/valid/busy=%b idx=%0d, required 0000 0",
               {i2s_clk_en, rx_en, frame_valid, busy}, frame_idx);
    end
    do_reset();
  endtask

  // Capture rules at frame level: complete array => present (or drop if the
  // previous frame is still waiting); partial array at a boundary => skew
  task automatic model_cycle(input logic [3:0] rv, input logic rdy, input bit fall, input logic clr);
    logic [3:0] seen;
    seen = m_mask | rv;
    if (clr) begin
      m_overrun = 0;
      m_skew = 0;
    end
    if (seen == 4'hF) begin
      if (m_valid && !rdy) m_overrun = 1;
      else begin
        m_valid = 1;
        m_idx = m_seq;
      end
      m_seq = m_seq + 16'd1;
      m_mask = 4'h0;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (fall) begin
        if (seen != 4'h0) m_skew = 1;
        m_mask = 4'h0;
      end else begin
        m_mask = seen;
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] mute, rv;
    logic rdy, clr;
    int rdy_mode, fail_at_start, m_acc;
    $display("test_random");
    bring_up();
    m_mask = 4'h0; m_valid = 0; m_idx = 16'd0; m_seq = 16'd0; m_overrun = 0; m_skew = 0;
    mute = 4'h0; rdy_mode = 1; m_acc = 0;
    fail_at_start = n_fail;
    for (int c = 0; c < 1600; c++) begin
      if (c % WS_PER == 0) begin
        mute = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
        rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      end
      rv = 4'h0;
      for (int i = 0; i < 4; i++) if (!mute[i] && $urandom_range(0, 31) == 0) rv[i] = 1'b1;
      rdy = (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 63) == 0);
      rx_valid = rv; bf_ready = rdy; clr_err = clr;
      if (m_valid && rdy) m_acc++;
      model_cycle(rv, rdy, fall_now, clr);
      step();
      n_checks++;
      if (frame_valid !== m_valid || (m_valid && frame_idx !== m_idx)) begin
        n_fail++;
        $display("FAIL rand_frame c=%0d: valid=%b idx=%0d, required valid=%b idx=%0d",
                 c, frame_valid, frame_idx, m_valid, m_idx);
      end
      n_checks++;
      if (err_overrun !== m_overrun || err_skew !== m_skew) begin
        n_fail++;
        $display("FAIL rand_errors c=%0d: ovr=%b skew=%b, required ovr=%b skew=%b",
                 c, err_overrun, err_skew, m_overrun, m_skew);
      end
      if (n_fail > fail_at_start + 8) break;
    end
    rx_valid = 4'h0; clr_err = 1'b0;
    n_checks++;
    if (acc_q.size() != m_acc) begin
      n_fail++;
      $display("FAIL rand_accept_count: got %0d, required %0d", acc_q.size(), m_acc);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_frames();
    test_overrun();
    test_skew();
    test_stop();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish within 2 ms");
    $fatal(1, "simulation time limit");
  end

endmodule
